// File: rtl/ula_seq_param.sv
// ula_seq_param -- parametrised sequential ALU with step-driven entry FSM.
//
// Operands and opcode are entered one per step pulse (LOAD_A, LOAD_B,
// LOAD_OP), the operation runs in EXEC and the result is committed on the
// EXEC->DONE edge. ADD/SUB/OR/AND/XOR/NOT take one EXEC cycle; MUL
// (shift-add) and DIV with a nonzero divisor (restoring) take WIDTH
// iterations plus one commit cycle. Committed results are pushed into a
// DEPTH-entry history ring.
//
// Ports:
//   CLOCK_50         system clock
//   reset_debounced  asynchronous active-low reset
//   step             one-cycle advance pulse
//   sw_data          operand A/B value
//   sw_op            opcode (ADD,SUB,OR,AND,XOR,MUL,DIV,NOT)
//   chain_en         use previous result as operand 1 (sampled on LOAD_A step)
//   hist_idx         history read index, 0 = most recent
//   state            FSM state encoding for LEDs
//   busy             high while in EXEC
//   result           last committed result (quotient for DIV)
//   remainder        DIV remainder, 0 after any other op
//   op_reg           latched opcode
//   flag_ovf/zero/neg/err  committed flags (ovf is sticky)
//   hist_data        history entry at hist_idx, 0 if not yet written
module ula_seq_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_debounced,
  input  logic                     step,
  input  logic [WIDTH-1:0]         sw_data,
  input  logic [2:0]               sw_op,
  input  logic                     chain_en,
  input  logic [$clog2(DEPTH)-1:0] hist_idx,
  output logic [2:0]               state,
  output logic                     busy,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         remainder,
  output logic [2:0]               op_reg,
  output logic                     flag_ovf,
  output logic                     flag_zero,
  output logic                     flag_neg,
  output logic                     flag_err,
  output logic [WIDTH-1:0]         hist_data
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int HCNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'b000,
    S_LOAD_B  = 3'b001,
    S_LOAD_OP = 3'b010,
    S_EXEC    = 3'b011,
    S_DONE    = 3'b100
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     op1_q;
  logic [WIDTH-1:0]     b_q;
  logic [2:0]           op_q;
  logic [2*WIDTH-1:0]   work_q;      // {hi, lo}: MUL {partial, multiplier}, DIV {rem, quotient}
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 ovf_q;
  logic                 zero_q;
  logic                 neg_q;
  logic                 err_q;
  logic                 have_prev_q;
  logic                 ready_q;     // low for the first edge after reset release
  logic [WIDTH-1:0]     hist_q [DEPTH];
  logic [IDX_W-1:0]     wr_ptr_q;
  logic [HCNT_W-1:0]    hcnt_q;

  logic                 step_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_try_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_sub_s;
  logic                 multi_s;
  logic                 commit_s;
  logic [2*WIDTH-1:0]   work_d;
  logic [WIDTH-1:0]     res_d;
  logic [WIDTH-1:0]     rem_d;
  logic                 ovf_d;
  logic                 neg_d;
  logic                 err_d;
  logic [IDX_W-1:0]     rd_ptr_s;

  // Datapath: single-cycle results, one MUL/DIV iteration step and commit values.
  always_comb begin
    step_s    = step & ready_q;
    sum_s     = {1'b0, op1_q} + {1'b0, b_q};
    diff_s    = {1'b0, op1_q} - {1'b0, b_q};
    mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, op1_q} : {(WIDTH+1){1'b0}});
    div_try_s = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge_s  = (div_try_s >= {1'b0, b_q});
    // Partial remainder is below 2*B, so the difference always fits WIDTH bits.
    div_sub_s = div_try_s[WIDTH-1:0] - b_q;
    work_d    = (op_q == OP_MUL) ? {mul_sum_s, work_q[WIDTH-1:1]}
                                 : {(div_ge_s ? div_sub_s : div_try_s[WIDTH-1:0]),
                                    work_q[WIDTH-2:0], div_ge_s};
    multi_s   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != {WIDTH{1'b0}}));
    commit_s  = !multi_s || (cnt_q == CNT_W'(WIDTH));
    res_d     = {WIDTH{1'b0}};
    rem_d     = {WIDTH{1'b0}};
    ovf_d     = 1'b0;
    neg_d     = 1'b0;
    err_d     = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum_s[WIDTH-1:0];
        ovf_d = sum_s[WIDTH];
      end
      OP_SUB: begin
        res_d = diff_s[WIDTH-1:0];
        neg_d = diff_s[WIDTH];
      end
      OP_OR:  res_d = op1_q | b_q;
      OP_AND: res_d = op1_q & b_q;
      OP_XOR: res_d = op1_q ^ b_q;
      OP_MUL: begin
        res_d = work_q[WIDTH-1:0];
        ovf_d = |work_q[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        res_d = multi_s ? work_q[WIDTH-1:0] : {WIDTH{1'b1}};
        rem_d = multi_s ? work_q[2*WIDTH-1:WIDTH] : op1_q;
        err_d = !multi_s;
      end
      OP_NOT: res_d = ~op1_q;
      default: res_d = {WIDTH{1'b0}};
    endcase
  end

  // Entry FSM, iteration engine, commit registers and history ring.
  always_ff @(posedge CLOCK_50 or negedge reset_debounced) begin
    if (!reset_debounced) begin
      state_q     <= S_LOAD_A;
      op1_q       <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 3'b000;
      work_q      <= {(2*WIDTH){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      have_prev_q <= 1'b0;
      ready_q     <= 1'b0;
      wr_ptr_q    <= {IDX_W{1'b0}};
      hcnt_q      <= {HCNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        S_LOAD_A: if (step_s) begin
          op1_q   <= (chain_en && have_prev_q) ? result_q : sw_data;
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: if (step_s) begin
          b_q     <= sw_data;
          state_q <= S_LOAD_OP;
        end
        S_LOAD_OP: if (step_s) begin
          op_q    <= sw_op;
          cnt_q   <= {CNT_W{1'b0}};
          work_q  <= (sw_op == OP_MUL) ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, op1_q};
          busy_q  <= 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: if (commit_s) begin
          result_q         <= res_d;
          rem_q            <= rem_d;
          ovf_q            <= ovf_q | ovf_d;
          zero_q           <= (res_d == {WIDTH{1'b0}});
          neg_q            <= neg_d;
          err_q            <= err_d;
          have_prev_q      <= 1'b1;
          hist_q[wr_ptr_q] <= res_d;
          wr_ptr_q         <= wr_ptr_q + IDX_W'(1);
          if (hcnt_q != HCNT_W'(DEPTH)) begin
            hcnt_q <= hcnt_q + HCNT_W'(1);
          end
          busy_q           <= 1'b0;
          state_q          <= S_DONE;
        end else begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        S_DONE: if (step_s) begin
          state_q <= S_LOAD_A;
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  // History read: most recent entry sits just below the write pointer.
  always_comb begin
    rd_ptr_s  = wr_ptr_q - IDX_W'(1) - hist_idx;
    hist_data = (HCNT_W'(hist_idx) < hcnt_q) ? hist_q[rd_ptr_s] : {WIDTH{1'b0}};
  end

  assign state     = state_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign remainder = rem_q;
  assign op_reg    = op_q;
  assign flag_ovf  = ovf_q;
  assign flag_zero = zero_q;
  assign flag_neg  = neg_q;
  assign flag_err  = err_q;

endmodule

// File: tb/tb_ula_seq_param.sv
// Testbench for ula_seq_param (WIDTH=8, DEPTH=4): directed scenarios with
// literal expectations, then randomized operations checked every cycle
// against a transaction-level reference model.
module tb_ula_seq_param;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int IW   = 2;
  localparam int MASK = (1 << W) - 1;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_OR  = 2;
  localparam int OP_AND = 3;
  localparam int OP_XOR = 4;
  localparam int OP_MUL = 5;
  localparam int OP_DIV = 6;
  localparam int OP_NOT = 7;

  logic          CLOCK_50 = 1'b0;
  logic          reset_debounced;
  logic          step;
  logic [W-1:0]  sw_data;
  logic [2:0]    sw_op;
  logic          chain_en;
  logic [IW-1:0] hist_idx;
  logic [2:0]    state;
  logic          busy;
  logic [W-1:0]  result;
  logic [W-1:0]  remainder;
  logic [2:0]    op_reg;
  logic          flag_ovf;
  logic          flag_zero;
  logic          flag_neg;
  logic          flag_err;
  logic [W-1:0]  hist_data;

  always #5 CLOCK_50 = ~CLOCK_50;

  ula_seq_param #(.WIDTH(W), .DEPTH(D)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset_debounced (reset_debounced),
    .step            (step),
    .sw_data         (sw_data),
    .sw_op           (sw_op),
    .chain_en        (chain_en),
    .hist_idx        (hist_idx),
    .state           (state),
    .busy            (busy),
    .result          (result),
    .remainder       (remainder),
    .op_reg          (op_reg),
    .flag_ovf        (flag_ovf),
    .flag_zero       (flag_zero),
    .flag_neg        (flag_neg),
    .flag_err        (flag_err),
    .hist_data       (hist_data)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model state (transaction level).
  int m_state, m_busy, m_result, m_rem, m_op, m_ovf, m_zero, m_neg, m_err;
  int m_have_prev, m_op1, m_b;
  int m_hist[$];
  int busy_cnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_hist(input int idx);
    if (idx < m_hist.size()) return m_hist[m_hist.size() - 1 - idx];
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_busy = 0; m_result = 0; m_rem = 0; m_op = 0;
    m_ovf = 0; m_zero = 0; m_neg = 0; m_err = 0;
    m_have_prev = 0; m_op1 = 0; m_b = 0;
    m_hist.delete();
  endtask

  // Arithmetic rules of the ALU, in plain integer arithmetic.
  function automatic void compute(input int op, input int a, input int b,
                                  output int res, output int rem, output int ovf,
                                  output int neg, output int err, output int lat);
    int s;
    res = 0; rem = 0; ovf = 0; neg = 0; err = 0; lat = 1;
    case (op)
      OP_ADD: begin s = a + b; res = s % (MASK + 1); ovf = (s > MASK) ? 1 : 0; end
      OP_SUB: begin res = (a - b + MASK + 1) % (MASK + 1); neg = (a < b) ? 1 : 0; end
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_MUL: begin s = a * b; res = s % (MASK + 1); ovf = (s > MASK) ? 1 : 0; lat = W + 1; end
      OP_DIV: begin
        if (b == 0) begin res = MASK; rem = a; err = 1; end
        else begin res = a / b; rem = a % b; lat = W + 1; end
      end
      default: res = MASK - a;
    endcase
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      cmp("state",     32'(state),     m_state);
      cmp("busy",      32'(busy),      m_busy);
      cmp("result",    32'(result),    m_result);
      cmp("remainder", 32'(remainder), m_rem);
      cmp("op_reg",    32'(op_reg),    m_op);
      cmp("flag_ovf",  32'(flag_ovf),  m_ovf);
      cmp("flag_zero", 32'(flag_zero), m_zero);
      cmp("flag_neg",  32'(flag_neg),  m_neg);
      cmp("flag_err",  32'(flag_err),  m_err);
      cmp("hist_data", 32'(hist_data), exp_hist(int'(hist_idx)));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    hist_idx = IW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step     = 1'b0;
      sw_data  = W'($urandom);
      sw_op    = 3'($urandom);
      chain_en = 1'($urandom);
      tick();
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic reset_assert();
    reset_debounced = 1'b0;
    model_reset();
  endtask

  // Release reset with step optionally high on the first edge (must be ignored).
  task automatic reset_release(input bit step_hi);
    reset_debounced = 1'b1;
    step = step_hi;
    tick();
    step = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int op, input bit chain,
                        input int abort_at, output bit aborted);
    int res, rem, ovf, neg, err, lat;
    aborted = 1'b0;
    idle($urandom_range(0, 2));
    sw_data = W'(a); chain_en = chain; do_step();
    m_op1 = (chain && m_have_prev != 0) ? m_result : a;
    m_state = 1;
    idle($urandom_range(0, 2));
    sw_data = W'(b); do_step();
    m_b = b; m_state = 2;
    idle($urandom_range(0, 2));
    sw_op = 3'(op); do_step();
    m_op = op; m_state = 3; m_busy = 1;
    busy_cnt = int'(busy);
    compute(op, m_op1, m_b, res, rem, ovf, neg, err, lat);
    for (int k = 1; k <= lat; k++) begin
      step    = (k == 1) ? 1'b1 : 1'($urandom);
      sw_data = W'($urandom);
      tick();
      step = 1'b0;
      if (k < lat) begin
        busy_cnt += int'(busy);
        if (k == abort_at) begin
          reset_assert();
          aborted = 1'b1;
          return;
        end
      end else begin
        m_state = 4; m_busy = 0;
        m_result = res; m_rem = rem;
        m_ovf = m_ovf | ovf; m_zero = (res == 0) ? 1 : 0;
        m_neg = neg; m_err = err; m_have_prev = 1;
        m_hist.push_back(res);
        if (m_hist.size() > D) void'(m_hist.pop_front());
      end
    end
    idle($urandom_range(0, 2));
    do_step();
    m_state = 0;
  endtask

  task automatic pin_hist(input int idx, input int exp);
    tick();
    hist_idx = IW'(idx);
    #1;
    cmp($sformatf("hist_pin[%0d]", idx), 32'(hist_data), exp);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    int a, b, op, abort_at;
    reset_debounced = 1'b0; step = 1'b0; sw_data = '0; sw_op = '0;
    chain_en = 1'b0; hist_idx = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    cmp("rst_state", 32'(state), 32'd0);
    cmp("rst_result", 32'(result), 32'd0);
    reset_release(1'b1);
    cmp("release_step_ignored", 32'(state), 32'd0);

    run_op(200, 100, OP_ADD, 1'b0, 0, ab);
    cmp("add_result", 32'(result), 32'd44);
    cmp("add_ovf", 32'(flag_ovf), 32'd1);
    run_op(1, 1, OP_ADD, 1'b0, 0, ab);
    cmp("add2_result", 32'(result), 32'd2);
    cmp("add2_ovf_sticky", 32'(flag_ovf), 32'd1);

    reset_assert(); tick(); reset_release(1'b0);
    run_op(13, 11, OP_MUL, 1'b0, 0, ab);
    cmp("mul_busy_cycles", 32'(busy_cnt), 32'd9);
    cmp("mul_result", 32'(result), 32'd143);
    cmp("mul_ovf", 32'(flag_ovf), 32'd0);
    run_op(255, 2, OP_MUL, 1'b0, 0, ab);
    cmp("mul2_result", 32'(result), 32'd254);
    cmp("mul2_ovf", 32'(flag_ovf), 32'd1);

    reset_assert(); tick(); reset_release(1'b0);
    run_op(100, 7, OP_DIV, 1'b0, 0, ab);
    cmp("div_result", 32'(result), 32'd14);
    cmp("div_rem", 32'(remainder), 32'd2);
    cmp("div_err", 32'(flag_err), 32'd0);
    run_op(100, 0, OP_DIV, 1'b0, 0, ab);
    cmp("div0_result", 32'(result), 32'd255);
    cmp("div0_rem", 32'(remainder), 32'd100);
    cmp("div0_err", 32'(flag_err), 32'd1);
    cmp("div0_busy_cycles", 32'(busy_cnt), 32'd1);

    run_op(5, 9, OP_SUB, 1'b0, 0, ab);
    cmp("sub_result", 32'(result), 32'd252);
    cmp("sub_neg", 32'(flag_neg), 32'd1);
    cmp("sub_rem", 32'(remainder), 32'd0);
    run_op(77, 252, OP_SUB, 1'b1, 0, ab);
    cmp("chain_result", 32'(result), 32'd0);
    cmp("chain_zero", 32'(flag_zero), 32'd1);
    cmp("chain_neg", 32'(flag_neg), 32'd0);

    reset_assert(); tick(); reset_release(1'b0);
    for (int k = 1; k <= 5; k++) run_op(0, k, OP_ADD, 1'b0, 0, ab);
    pin_hist(0, 5);
    pin_hist(1, 4);
    pin_hist(2, 3);
    pin_hist(3, 2);
    reset_assert(); tick(); reset_release(1'b0);
    for (int k = 0; k < D; k++) pin_hist(k, 0);

    run_op(3, 4, OP_ADD, 1'b0, 0, ab);
    run_op(13, 11, OP_MUL, 1'b0, 3, ab);
    #1;
    cmp("abort_taken", 32'(ab), 32'd1);
    cmp("abort_state", 32'(state), 32'd0);
    cmp("abort_result", 32'(result), 32'd0);
    cmp("abort_busy", 32'(busy), 32'd0);
    hist_idx = '0; #1;
    cmp("abort_hist", 32'(hist_data), 32'd0);
    tick();
    reset_release(1'b1);

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, MASK);
      b  = $urandom_range(0, MASK);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 0 : MASK;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 1 : MASK;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 0;
      abort_at = ($urandom_range(0, 24) == 0) ? $urandom_range(1, W) : 0;
      run_op(a, b, op, 1'($urandom), abort_at, ab);
      if (ab) begin
        repeat ($urandom_range(0, 2)) tick();
        reset_release(1'($urandom));
      end else if ($urandom_range(0, 39) == 0) begin
        reset_assert();
        tick();
        reset_release(1'($urandom));
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
